// File: rtl/config_read_arbiter_pkg.sv
// rtl/config_read_arbiter_pkg.sv - shared types and constants for the config read path
package config_read_arbiter_pkg;

    // Width of a config register read response.
    localparam int AXIL_DATA_BITS = 32;

    // Cycles a transaction may spend in ISSUE+WAIT before it is forced to an error.
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // Width of an index selecting one of n requesters; never narrower than one bit.
    function automatic int index_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/config_read_arbiter_if.sv
// rtl/config_read_arbiter_if.sv - downstream config read port between arbiter and register file
interface config_read_arbiter_if
    import config_read_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = AXIL_DATA_BITS
);

    logic                 m_read_valid;
    logic                 m_read_ready;
    logic [ADDR_BITS-1:0] m_read_addr;
    logic                 m_resp_valid;
    logic                 m_resp_ready;
    logic [DATA_BITS-1:0] m_resp_data;
    logic                 m_resp_error;

    // Arbiter side: issues reads and accepts responses.
    modport master (
        output m_read_valid,
        output m_read_addr,
        output m_resp_ready,
        input  m_read_ready,
        input  m_resp_valid,
        input  m_resp_data,
        input  m_resp_error
    );

    // Register file side: accepts reads and returns responses.
    modport slave (
        input  m_read_valid,
        input  m_read_addr,
        input  m_resp_ready,
        output m_read_ready,
        output m_resp_valid,
        output m_resp_data,
        output m_resp_error
    );

endinterface

// File: rtl/config_read_arbiter_rr_arbiter.sv
// rtl/config_read_arbiter_rr_arbiter.sv - combinational round-robin pick from a start pointer
module config_read_arbiter_rr_arbiter
    import config_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_BITS = index_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_valid
);

    logic [IDX_BITS-1:0] cand;

    // First active request at or after rr_ptr, wrapping past the top index.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_BITS'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/config_read_arbiter.sv
// rtl/config_read_arbiter.sv - round-robin sharing of one config read port with response timeout
module config_read_arbiter
    import config_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BITS      = 16,
    parameter int DATA_BITS      = AXIL_DATA_BITS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_read_valid,
    output logic [NUM_REQ-1:0]   req_read_ready,
    input  logic [ADDR_BITS-1:0] req_read_addr [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_resp_valid,
    input  logic [NUM_REQ-1:0]   req_resp_ready,
    output logic [DATA_BITS-1:0] req_resp_data,
    output logic                 req_resp_error,
    config_read_arbiter_if.master m_if,
    output logic                 timeout_seen
);

    localparam int IDX_BITS   = index_bits(NUM_REQ);
    localparam int TIMER_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TIMER_BITS-1:0] TIMER_MAX  = TIMER_BITS'(TIMEOUT_CYCLES);
    localparam logic [TIMER_BITS-1:0] TIMER_LAST =
        TIMER_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    if (NUM_REQ < 1) begin : g_bad_num_req
        $error("config_read_arbiter: NUM_REQ must be at least 1");
    end
    if (TIMEOUT_CYCLES < 0) begin : g_bad_timeout
        $error("config_read_arbiter: TIMEOUT_CYCLES must not be negative");
    end

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   grant_q;
    logic [IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_BITS-1:0]  data_q;
    logic                  error_q;
    logic [TIMER_BITS-1:0] timer_q, timer_d, timer_inc;
    logic                  timer_expired;
    logic                  drain_q, drain_d;
    logic                  timeout_seen_q;
    logic                  load_req, load_resp, load_timeout;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDX_BITS-1:0]   arb_idx;
    logic                  arb_valid;

    config_read_arbiter_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_arbiter (
        .req         (req_read_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // The timer saturates so a disabled or already-fired timeout never wraps around.
    assign timer_inc     = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_BITS'(1);
    // Expiry is flagged on the last counted cycle so the transaction leaves after exactly
    // TIMEOUT_CYCLES cycles in ISSUE+WAIT.
    assign timer_expired = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST);

    assign m_if.m_read_addr = addr_q;
    assign req_resp_data    = data_q;
    assign req_resp_error   = error_q;
    assign timeout_seen     = timeout_seen_q;

    // Next-state, handshake outputs and register load strobes for one transaction at a time.
    always_comb begin
        state_d             = state_q;
        timer_d             = timer_q;
        drain_d             = drain_q;
        rr_ptr_d            = rr_ptr_q;
        load_req            = 1'b0;
        load_resp           = 1'b0;
        load_timeout        = 1'b0;
        req_read_ready      = '0;
        req_resp_valid      = '0;
        m_if.m_read_valid   = 1'b0;
        m_if.m_resp_ready   = drain_q;

        // A response seen while draining belongs to an abandoned transaction: swallow it.
        if (drain_q && m_if.m_resp_valid) begin
            drain_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    req_read_ready = arb_grant;
                    load_req       = 1'b1;
                    timer_d        = '0;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                m_if.m_read_valid = 1'b1;
                timer_d           = timer_inc;
                if (m_if.m_read_ready) begin
                    state_d = WAIT;
                end else if (timer_expired) begin
                    load_timeout = 1'b1;
                    state_d      = RESPOND;
                end
            end
            WAIT: begin
                m_if.m_resp_ready = 1'b1;
                timer_d           = timer_inc;
                if (m_if.m_resp_valid && !drain_q) begin
                    load_resp = 1'b1;
                    state_d   = RESPOND;
                end else if (timer_expired) begin
                    load_timeout = 1'b1;
                    drain_d      = 1'b1;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                req_resp_valid[grant_q] = 1'b1;
                if (req_resp_ready[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_q + IDX_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request/response payload, timer, drain and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            error_q        <= 1'b0;
            timer_q        <= '0;
            drain_q        <= 1'b0;
            timeout_seen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            drain_q  <= drain_d;
            rr_ptr_q <= rr_ptr_d;
            if (load_req) begin
                grant_q <= arb_idx;
                addr_q  <= req_read_addr[arb_idx];
            end
            if (load_resp) begin
                data_q  <= m_if.m_resp_data;
                error_q <= m_if.m_resp_error;
            end else if (load_timeout) begin
                data_q         <= '0;
                error_q        <= 1'b1;
                timeout_seen_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_config_read_arbiter.sv
// tb/tb_config_read_arbiter.sv - directed self-checking bench for config_read_arbiter
module tb_config_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_read_valid = '0;
    logic [3:0]  req_read_ready;
    logic [15:0] req_read_addr [4];
    logic [3:0]  req_resp_valid;
    logic [3:0]  req_resp_ready = '1;
    logic [31:0] req_resp_data;
    logic        req_resp_error;
    logic        timeout_seen;

    logic        auto_slave = 1'b1;
    logic        man_read_ready = 1'b0;
    logic        man_resp_valid = 1'b0;
    logic        man_resp_error = 1'b0;
    logic [31:0] man_resp_data = '0;
    logic [31:0] slave_data = '0;
    logic        auto_pend = 1'b0;
    logic        auto_rsp_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    config_read_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(32)) bus ();

    config_read_arbiter #(
        .NUM_REQ        (4),
        .ADDR_BITS      (16),
        .DATA_BITS      (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_read_valid (req_read_valid),
        .req_read_ready (req_read_ready),
        .req_read_addr  (req_read_addr),
        .req_resp_valid (req_resp_valid),
        .req_resp_ready (req_resp_ready),
        .req_resp_data  (req_resp_data),
        .req_resp_error (req_resp_error),
        .m_if           (bus),
        .timeout_seen   (timeout_seen)
    );

    always #5 clk = ~clk;

    assign bus.m_read_ready = auto_slave ? 1'b1 : man_read_ready;
    assign bus.m_resp_valid = auto_slave ? auto_rsp_valid : man_resp_valid;
    assign bus.m_resp_data  = auto_slave ? slave_data : man_resp_data;
    assign bus.m_resp_error = auto_slave ? 1'b0 : man_resp_error;

    // Zero-wait slave: accepts every read and responds on the following cycle.
    always @(negedge clk) begin
        if (!auto_slave || !rst_n) begin
            auto_pend      <= 1'b0;
            auto_rsp_valid <= 1'b0;
        end else begin
            auto_rsp_valid <= auto_pend;
            auto_pend      <= bus.m_read_valid;
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        req_read_valid = '0;
        req_resp_ready = '1;
        auto_slave     = 1'b1;
        man_read_ready = 1'b0;
        man_resp_valid = 1'b0;
        man_resp_data  = '0;
        man_resp_error = 1'b0;
        slave_data     = '0;
        for (int i = 0; i < 4; i++) req_read_addr[i] = 16'h0100 + 16'(i);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (req_read_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_read_ready got %b want 0000", req_read_ready); end
        n_cmp++; if (req_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_resp_valid got %b want 0000", req_resp_valid); end
        n_cmp++; if (bus.m_read_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_read_valid got %b want 0", bus.m_read_valid); end
        n_cmp++; if (bus.m_resp_ready !== 1'b0) begin n_bad++; $display("FAIL rst_m_resp_ready got %b want 0", bus.m_resp_ready); end
        n_cmp++; if (req_resp_data !== 32'h0) begin n_bad++; $display("FAIL rst_resp_data got %h want 0", req_resp_data); end
        n_cmp++; if (req_resp_error !== 1'b0) begin n_bad++; $display("FAIL rst_resp_error got %b want 0", req_resp_error); end
        n_cmp++; if (timeout_seen !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_seen got %b want 0", timeout_seen); end
    endtask

    task automatic test_single();
        slave_data       = 32'h0000_DEAD;
        req_read_addr[1] = 16'h0003;
        req_read_valid   = 4'b0010;
        #1;
        n_cmp++; if (req_read_ready !== 4'b0010) begin n_bad++; $display("FAIL single_read_ready got %b want 0010", req_read_ready); end
        @(negedge clk); req_read_valid = '0; #1;
        n_cmp++; if (bus.m_read_valid !== 1'b1) begin n_bad++; $display("FAIL single_m_read_valid got %b want 1", bus.m_read_valid); end
        n_cmp++; if (bus.m_read_addr !== 16'h0003) begin n_bad++; $display("FAIL single_m_read_addr got %h want 0003", bus.m_read_addr); end
        @(negedge clk); #1;
        n_cmp++; if (bus.m_resp_ready !== 1'b1) begin n_bad++; $display("FAIL single_m_resp_ready got %b want 1", bus.m_resp_ready); end
        n_cmp++; if (req_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_resp_early got %b want 0000", req_resp_valid); end
        @(negedge clk); #1;
        n_cmp++; if (req_resp_valid !== 4'b0010) begin n_bad++; $display("FAIL single_resp_valid got %b want 0010", req_resp_valid); end
        n_cmp++; if (req_resp_data !== 32'h0000_DEAD) begin n_bad++; $display("FAIL single_resp_data got %h want 0000dead", req_resp_data); end
        n_cmp++; if (req_resp_error !== 1'b0) begin n_bad++; $display("FAIL single_resp_error got %b want 0", req_resp_error); end
        @(negedge clk); #1;
        n_cmp++; if (req_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_resp_done got %b want 0000", req_resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp4;
        logic [15:0] exp_a;
        int n;
        do_reset();
        slave_data     = 32'hA5A5_0000;
        req_read_valid = 4'b1111;
        #1;
        n_cmp++; if (req_read_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_first_ready got %b want 0001", req_read_ready); end
        for (int g = 0; g < 5; g++) begin
            exp4  = 4'b0001 << (g % 4);
            exp_a = 16'h0100 + 16'(g % 4);
            n = 0;
            while (req_resp_valid === 4'b0000 && n < 20) begin
                if (bus.m_read_valid === 1'b1) begin
                    n_cmp++; if (bus.m_read_addr !== exp_a) begin n_bad++; $display("FAIL rr_addr[%0d] got %h want %h", g, bus.m_read_addr, exp_a); end
                end
                @(negedge clk); #1; n++;
            end
            n_cmp++; if (req_resp_valid !== exp4) begin n_bad++; $display("FAIL rr_grant[%0d] got %b want %b", g, req_resp_valid, exp4); end
            @(negedge clk); #1;
        end
        req_read_valid = '0;
    endtask

    task automatic test_resp_backpressure();
        int n;
        do_reset();
        slave_data       = 32'h0000_BEEF;
        req_read_addr[2] = 16'h0222;
        req_resp_ready   = 4'b1011;
        req_read_valid   = 4'b0100;
        @(negedge clk);
        req_read_valid = 4'b0001;
        #1;
        n = 0;
        while (req_resp_valid === 4'b0000 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        n_cmp++; if (req_resp_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_resp_valid got %b want 0100", req_resp_valid); end
        n_cmp++; if (req_resp_data !== 32'h0000_BEEF) begin n_bad++; $display("FAIL bp_resp_data got %h want 0000beef", req_resp_data); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (req_resp_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got %b want 0100", c, req_resp_valid); end
            n_cmp++; if (req_resp_data !== 32'h0000_BEEF) begin n_bad++; $display("FAIL bp_hold_data[%0d] got %h want 0000beef", c, req_resp_data); end
            n_cmp++; if (bus.m_read_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_issue[%0d] got %b want 0", c, bus.m_read_valid); end
            n_cmp++; if (req_read_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_no_grant[%0d] got %b want 0000", c, req_read_ready); end
        end
        req_resp_ready = 4'b1111;
        @(negedge clk); #1;
        n_cmp++; if (req_read_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_next_ready got %b want 0001", req_read_ready); end
        req_read_valid = '0;
    endtask

    task automatic test_timeout_issue();
        int n;
        int n_issue;
        do_reset();
        auto_slave       = 1'b0;
        man_read_ready   = 1'b0;
        req_read_addr[3] = 16'h0033;
        req_read_valid   = 4'b1000;
        #1;
        n_cmp++; if (req_read_ready !== 4'b1000) begin n_bad++; $display("FAIL tmo_read_ready got %b want 1000", req_read_ready); end
        @(negedge clk); req_read_valid = '0; #1;
        n_cmp++; if (timeout_seen !== 1'b0) begin n_bad++; $display("FAIL tmo_seen_early got %b want 0", timeout_seen); end
        n = 0;
        n_issue = 0;
        while (req_resp_valid === 4'b0000 && n < 50) begin
            if (bus.m_read_valid === 1'b1) n_issue++;
            @(negedge clk); #1; n++;
        end
        n_cmp++; if (n_issue !== 8) begin n_bad++; $display("FAIL tmo_issue_cycles got %0d want 8", n_issue); end
        n_cmp++; if (req_resp_valid !== 4'b1000) begin n_bad++; $display("FAIL tmo_resp_valid got %b want 1000", req_resp_valid); end
        n_cmp++; if (req_resp_data !== 32'h0) begin n_bad++; $display("FAIL tmo_resp_data got %h want 0", req_resp_data); end
        n_cmp++; if (req_resp_error !== 1'b1) begin n_bad++; $display("FAIL tmo_resp_error got %b want 1", req_resp_error); end
        n_cmp++; if (timeout_seen !== 1'b1) begin n_bad++; $display("FAIL tmo_seen got %b want 1", timeout_seen); end
        n_cmp++; if (bus.m_read_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_read_dropped got %b want 0", bus.m_read_valid); end
        n_cmp++; if (bus.m_resp_ready !== 1'b0) begin n_bad++; $display("FAIL tmo_no_drain got %b want 0", bus.m_resp_ready); end
        @(negedge clk); #1;
        n_cmp++; if (req_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL tmo_resp_done got %b want 0000", req_resp_valid); end
        n_cmp++; if (timeout_seen !== 1'b1) begin n_bad++; $display("FAIL tmo_seen_sticky got %b want 1", timeout_seen); end
    endtask

    task automatic test_timeout_drain();
        do_reset();
        auto_slave       = 1'b0;
        req_read_addr[1] = 16'h0011;
        req_read_addr[2] = 16'h0022;
        req_read_valid   = 4'b0010;
        #1;
        n_cmp++; if (req_read_ready !== 4'b0010) begin n_bad++; $display("FAIL drn_read_ready got %b want 0010", req_read_ready); end
        @(negedge clk); req_read_valid = '0; man_read_ready = 1'b1; #1;
        n_cmp++; if (bus.m_read_valid !== 1'b1) begin n_bad++; $display("FAIL drn_issue got %b want 1", bus.m_read_valid); end
        @(negedge clk); man_read_ready = 1'b0; #1;
        n_cmp++; if (bus.m_resp_ready !== 1'b1) begin n_bad++; $display("FAIL drn_wait_ready got %b want 1", bus.m_resp_ready); end
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (req_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL drn_early_resp[c%0d] got %b want 0000", c, req_resp_valid); end
        end
        @(negedge clk); #1;
        n_cmp++; if (req_resp_valid !== 4'b0010) begin n_bad++; $display("FAIL drn_err_valid got %b want 0010", req_resp_valid); end
        n_cmp++; if (req_resp_data !== 32'h0) begin n_bad++; $display("FAIL drn_err_data got %h want 0", req_resp_data); end
        n_cmp++; if (req_resp_error !== 1'b1) begin n_bad++; $display("FAIL drn_err_error got %b want 1", req_resp_error); end
        n_cmp++; if (timeout_seen !== 1'b1) begin n_bad++; $display("FAIL drn_seen got %b want 1", timeout_seen); end
        @(negedge clk); #1;
        n_cmp++; if (bus.m_resp_ready !== 1'b1) begin n_bad++; $display("FAIL drn_idle_ready got %b want 1", bus.m_resp_ready); end
        repeat (3) @(negedge clk);
        req_read_valid = 4'b0100;
        @(negedge clk); req_read_valid = '0; man_read_ready = 1'b1; #1;
        n_cmp++; if (bus.m_read_addr !== 16'h0022) begin n_bad++; $display("FAIL drn_second_addr got %h want 0022", bus.m_read_addr); end
        @(negedge clk); man_read_ready = 1'b0;
        repeat (5) @(negedge clk);
        man_resp_valid = 1'b1;
        man_resp_data  = 32'h0000_0055;
        #1;
        n_cmp++; if (bus.m_resp_ready !== 1'b1) begin n_bad++; $display("FAIL drn_stale_ready got %b want 1", bus.m_resp_ready); end
        @(negedge clk); man_resp_data = 32'h0000_0077; #1;
        n_cmp++; if (req_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL drn_stale_consumed got %b want 0000", req_resp_valid); end
        n_cmp++; if (bus.m_resp_ready !== 1'b1) begin n_bad++; $display("FAIL drn_still_wait got %b want 1", bus.m_resp_ready); end
        @(negedge clk); man_resp_valid = 1'b0; #1;
        n_cmp++; if (req_resp_valid !== 4'b0100) begin n_bad++; $display("FAIL drn_second_valid got %b want 0100", req_resp_valid); end
        n_cmp++; if (req_resp_data !== 32'h0000_0077) begin n_bad++; $display("FAIL drn_second_data got %h want 00000077", req_resp_data); end
        n_cmp++; if (req_resp_error !== 1'b0) begin n_bad++; $display("FAIL drn_second_error got %b want 0", req_resp_error); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        auto_slave     = 1'b0;
        man_read_ready = 1'b1;
        man_resp_valid = 1'b0;
        req_read_valid = 4'b0100;
        #1;
        n_cmp++; if (req_read_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_read_ready got %b want 0100", req_read_ready); end
        @(negedge clk); req_read_valid = '0;
        @(negedge clk); #1;
        n_cmp++; if (bus.m_resp_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_wait got %b want 1", bus.m_resp_ready); end
        n_cmp++; if (timeout_seen !== 1'b1) begin n_bad++; $display("FAIL mid_seen_before got %b want 1", timeout_seen); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (req_read_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_read_ready_rst got %b want 0000", req_read_ready); end
        n_cmp++; if (req_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_resp_valid_rst got %b want 0000", req_resp_valid); end
        n_cmp++; if (bus.m_read_valid !== 1'b0) begin n_bad++; $display("FAIL mid_m_read_valid_rst got %b want 0", bus.m_read_valid); end
        n_cmp++; if (bus.m_resp_ready !== 1'b0) begin n_bad++; $display("FAIL mid_m_resp_ready_rst got %b want 0", bus.m_resp_ready); end
        n_cmp++; if (req_resp_data !== 32'h0) begin n_bad++; $display("FAIL mid_resp_data_rst got %h want 0", req_resp_data); end
        n_cmp++; if (req_resp_error !== 1'b0) begin n_bad++; $display("FAIL mid_resp_error_rst got %b want 0", req_resp_error); end
        n_cmp++; if (timeout_seen !== 1'b0) begin n_bad++; $display("FAIL mid_seen_rst got %b want 0", timeout_seen); end
        rst_n          = 1'b1;
        req_read_valid = 4'b1111;
        #1;
        n_cmp++; if (req_read_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_next_grant got %b want 0001", req_read_ready); end
        @(negedge clk);
        req_read_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_resp_backpressure();
        test_timeout_issue();
        test_timeout_drain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
